// File: rtl/dtw_job_ctrl_if.sv
// Host command, core control and job status bundle between the host wrapper,
// dtw_job_ctrl (slave side) and dtw_core.
interface dtw_job_ctrl_if #(
    parameter int QCNT_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_ref_len;
    logic [QCNT_W-1:0] cmd_num_qry;
    logic              cmd_skip_ref;
    logic              abort;
    logic              core_rs;
    logic              core_op_mode;
    logic [31:0]       core_ref_len;
    logic              core_busy;
    logic              core_load_done;
    logic              core_sink_wren;
    logic              ref_loaded;
    logic [QCNT_W-1:0] qry_done_cnt;
    logic [31:0]       result_cnt;
    logic              job_done;
    logic              job_err;
    logic [31:0]       perf_cycles;

    modport slave (
        input  cmd_valid, cmd_ref_len, cmd_num_qry, cmd_skip_ref, abort,
        input  core_busy, core_load_done, core_sink_wren,
        output cmd_ready, core_rs, core_op_mode, core_ref_len, ref_loaded,
        output qry_done_cnt, result_cnt, job_done, job_err, perf_cycles
    );

    modport master (
        output cmd_valid, cmd_ref_len, cmd_num_qry, cmd_skip_ref, abort,
        output core_busy, core_load_done, core_sink_wren,
        input  cmd_ready, core_rs, core_op_mode, core_ref_len, ref_loaded,
        input  qry_done_cnt, result_cnt, job_done, job_err, perf_cycles
    );
endinterface

// File: rtl/dtw_job_ctrl.sv
// Job sequencer for dtw_core: optional reference load, then N query runs.
// Define DTWC_PERF_CNT_EN to build the accept-to-DONE cycle counter.
module dtw_job_ctrl #(
    parameter int QCNT_W      = 16,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    dtw_job_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REF_ARM = 3'd1;
    localparam logic [2:0] S_REF_RUN = 3'd2;
    localparam logic [2:0] S_Q_ARM   = 3'd3;
    localparam logic [2:0] S_Q_RUN   = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam int TMR_W = $clog2(ARM_TIMEOUT) + 1;

    logic [2:0]        state;
    logic [TMR_W-1:0]  arm_tmr;
    logic [QCNT_W-1:0] num_qry;
    logic [QCNT_W-1:0] qry_done_cnt;
    logic [31:0]       result_cnt;
    logic [31:0]       core_ref_len;
    logic              core_rs;
    logic              core_op_mode;
    logic              ref_loaded;
    logic              job_done;
    logic              job_err;
    logic              need_load;

    assign need_load = !bus.cmd_skip_ref || !ref_loaded;

    assign bus.cmd_ready    = (state == S_IDLE);
    assign bus.core_rs      = core_rs;
    assign bus.core_op_mode = core_op_mode;
    assign bus.core_ref_len = core_ref_len;
    assign bus.ref_loaded   = ref_loaded;
    assign bus.qry_done_cnt = qry_done_cnt;
    assign bus.result_cnt   = result_cnt;
    assign bus.job_done     = job_done;
    assign bus.job_err      = job_err;

    // core_rs is registered and set on the edge that enters an ARM state, so
    // GAP is the only rs-low cycle between back-to-back phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            arm_tmr      <= '0;
            num_qry      <= '0;
            qry_done_cnt <= '0;
            result_cnt   <= '0;
            core_ref_len <= '0;
            core_rs      <= 1'b0;
            core_op_mode <= 1'b0;
            ref_loaded   <= 1'b0;
            job_done     <= 1'b0;
            job_err      <= 1'b0;
        end else begin
            job_done <= 1'b0;
            if (state != S_IDLE && bus.core_sink_wren && result_cnt != 32'hFFFF_FFFF)
                result_cnt <= result_cnt + 32'd1;

            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        core_ref_len <= bus.cmd_ref_len;
                        num_qry      <= bus.cmd_num_qry;
                        qry_done_cnt <= '0;
                        result_cnt   <= '0;
                        job_err      <= 1'b0;
                        arm_tmr      <= '0;
                        if (need_load && bus.cmd_ref_len == 32'd0) begin
                            state    <= S_DONE;
                            job_err  <= 1'b1;
                            job_done <= 1'b1;
                        end else if (need_load) begin
                            state        <= S_REF_ARM;
                            core_op_mode <= 1'b1;
                            core_rs      <= 1'b1;
                            ref_loaded   <= 1'b0;
                        end else if (bus.cmd_num_qry != '0) begin
                            state        <= S_Q_ARM;
                            core_op_mode <= 1'b0;
                            core_rs      <= 1'b1;
                        end else begin
                            state    <= S_DONE;
                            job_done <= 1'b1;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (bus.abort) begin
                        state    <= S_DONE;
                        core_rs  <= 1'b0;
                        job_err  <= 1'b1;
                        job_done <= 1'b1;
                    end else begin
                        case (state)
                            S_REF_ARM, S_Q_ARM: begin
                                if (bus.core_busy) begin
                                    state <= (state == S_REF_ARM) ? S_REF_RUN : S_Q_RUN;
                                end else if (arm_tmr == TMR_W'(ARM_TIMEOUT - 1)) begin
                                    state    <= S_DONE;
                                    core_rs  <= 1'b0;
                                    job_err  <= 1'b1;
                                    job_done <= 1'b1;
                                end else begin
                                    arm_tmr <= arm_tmr + TMR_W'(1);
                                end
                            end
                            S_REF_RUN: begin
                                if (bus.core_load_done && !bus.core_busy) begin
                                    state      <= S_GAP;
                                    core_rs    <= 1'b0;
                                    ref_loaded <= 1'b1;
                                end
                            end
                            S_Q_RUN: begin
                                if (!bus.core_busy) begin
                                    state        <= S_GAP;
                                    core_rs      <= 1'b0;
                                    qry_done_cnt <= qry_done_cnt + QCNT_W'(1);
                                end
                            end
                            S_GAP: begin
                                if (qry_done_cnt < num_qry) begin
                                    state        <= S_Q_ARM;
                                    core_op_mode <= 1'b0;
                                    core_rs      <= 1'b1;
                                    arm_tmr      <= '0;
                                end else begin
                                    state    <= S_DONE;
                                    job_done <= 1'b1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef DTWC_PERF_CNT_EN
    logic [31:0] perf_q;

    // Counts every non-IDLE cycle, i.e. from the cycle after accept through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_q <= '0;
        else if (state == S_IDLE && bus.cmd_valid)
            perf_q <= '0;
        else if (state != S_IDLE && perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end

    assign bus.perf_cycles = perf_q;
`else
    assign bus.perf_cycles = '0;
`endif
endmodule
